rvc_asap_5pl_dmem_arb: RTL and testbench
========================================

# rvc_asap_5pl_dmem_arb

Two-master arbiter for the data memory port of the 5-stage core. It shares the single sync-read data memory between the core's Q103H memory stage and an external master, such as a program loader or debug/DMA engine. The core has fixed priority, and a starvation counter bounds the external master's wait. Read data returns one cycle after grant and is steered to the granted master.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- STARVE_MAX, 8, maximum consecutive core grants while the external request is pending (legal range 1..255)

- Clock  input  1  core clock
- Rst  input  1  reset; asynchronous, active-low
- CoreReq  input  1  core data access valid in Q103H
- CoreWrEn  input  1  core write (0 = read)
- CoreAddr  input  ADDR_W  core address
- CoreWrData  input  DATA_W  core write data
- CoreByteEn  input  DATA_W/8  core byte enables
- CoreStall  output  1  core access not granted this cycle; core must hold request
- CoreRdDataQ104H  output  DATA_W  read data for core
- ExtReq  input  1  external request valid
- ExtWrEn  input  1  external write
- ExtAddr  input  ADDR_W  external address
- ExtWrData  input  DATA_W  external write data
- ExtByteEn  input  DATA_W/8  external byte enables
- ExtGnt  output  1  external request accepted this cycle
- ExtRspValid  output  1  ExtRdData valid
- ExtRdData  output  DATA_W  read data for external master
- MemAddr, MemWrData, MemByteEn  output  ADDR_W / DATA_W / DATA_W/8  to memory
- MemWrEn, MemRdEn  output  1  memory strobes
- MemRdData  input  DATA_W  memory q (one cycle after strobe)

## Operation
- Grant is combinational each cycle:
  - ExtWin = ExtReq && (!CoreReq || StarveCnt == STARVE_MAX).
  - The core is granted when CoreReq && !ExtWin.
  - The external master is granted when ExtWin.
- Memory outputs mux from the granted master.
  - MemWrEn = granted WrEn.
  - MemRdEn = granted && !WrEn.
  - With no grant, both strobes are 0 and the address/data outputs are don't-care.
- CoreStall = CoreReq && ExtWin.
- ExtGnt = ExtWin.
- External handshake: ExtReq and all Ext* fields stay stable from assertion until the cycle ExtGnt = 1. A write completes at grant and produces no response.
- StarveCnt, width $clog2(STARVE_MAX+1):
  - Cleared when !ExtReq or when the external master is granted.
  - Otherwise increments on each core grant while ExtReq = 1, saturating at STARVE_MAX.
- Response owner register RspOwner (NONE/CORE/EXT) is set each cycle from the granted read; NONE for writes or idle.
- ExtRspValid = (RspOwner == EXT). ExtRdData = MemRdData.
- CoreRdDataQ104H = MemRdData when RspOwner == CORE, else 0.
- Reset (Rst low) is asynchronous:
  - StarveCnt = 0 and RspOwner = NONE, so ExtRspValid = 0 and CoreRdDataQ104H = 0.
  - While Rst is low: ExtGnt, CoreStall, MemWrEn and MemRdEn are forced to 0.
  - An in-flight read response is dropped if reset falls mid-access.

## Timing
- Grant, stall and memory strobes are combinational and asserted in the request cycle.
- Read data is valid exactly 1 cycle after the grant cycle: Q104H for the core, ExtRspValid for the external master.
- Back-to-back grants every cycle are legal; a response and a new grant can coincide in one cycle.
- External worst-case wait under a continuous core load is STARVE_MAX+1 cycles from ExtReq to ExtGnt.
- Core stall lasts exactly 1 cycle per external win; the core is always granted in the following cycle.
- A simultaneous request with StarveCnt < STARVE_MAX goes to the core.

## Structure
- Shared package rvc_asap_pkg holds:
  - typedef enum t_dmem_owner {OWN_NONE, OWN_CORE, OWN_EXT}.
  - DMEM_ARB_STARVE_MAX default constant.
- Flops use the team's async-reset flop macro variant.
- Single flat module; no sub-module.
- Instantiated in the mem wrap in front of the data memory; region decode gates CoreReq.

## Test plan
- Core reads only: CoreReq = 1 at addr 0x1000 where the memory holds 0xDEADBEEF, ExtReq = 0.
  - Required: MemRdEn = 1 in the same cycle, CoreRdDataQ104H = 0xDEADBEEF next cycle, CoreStall = 0.
- External write while the core is idle: ExtReq = 1, ExtWrEn = 1, addr 0x1004, data 0x12345678, byte enables 0xF.
  - Required: ExtGnt = 1 in the same cycle, MemWrEn = 1, no ExtRspValid.
  - A subsequent core read of 0x1004 returns 0x12345678.
- Starvation: CoreReq held at 1, ExtReq read asserted, STARVE_MAX = 8.
  - Required: 8 core grants, then on the 9th cycle ExtGnt = 1 and CoreStall = 1.
  - Next cycle: ExtRspValid = 1, the core is granted, and StarveCnt = 0.
- Simultaneous first request: CoreReq and ExtReq assert together with StarveCnt = 0.
  - Required: the core is granted and ExtGnt = 0.
- Reset mid-read: Rst is driven low in the cycle after an external read grant.
  - Required: ExtRspValid = 0 immediately, with no grants or strobes while Rst is low.
  - After release, the pending external request is granted normally.

Source files
------------

// File: rtl/rvc_asap_pkg.sv
// -----------------------------------------------------------------------------
// rvc_asap_pkg
// Shared definitions for the rvc_asap 5-stage core memory subsystem.
//   t_dmem_owner        : which master owns the read response in flight
//   DMEM_ARB_STARVE_MAX : default bound on consecutive core grants while the
//                         external master is waiting
// -----------------------------------------------------------------------------
package rvc_asap_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CORE = 2'd1,
        OWN_EXT  = 2'd2
    } t_dmem_owner;

    localparam int DMEM_ARB_STARVE_MAX = 8;

endpackage

// File: rtl/rvc_asap_5pl_dmem_arb.sv
// -----------------------------------------------------------------------------
// rvc_asap_5pl_dmem_arb
// Two-master arbiter in front of the single sync-read data memory.
// The core (Q103H memory stage) has fixed priority; a starvation counter
// hands the port to the external master (loader / debug / DMA) after
// STARVE_MAX consecutive core grants while it waits.
//
// Ports
//   Clock, Rst            : clock, asynchronous active-low reset
//   Core*                 : core request (Q103H), CoreStall back-pressure,
//                           CoreRdDataQ104H read data one cycle later
//   Ext*                  : external request, ExtGnt accept strobe,
//                           ExtRspValid/ExtRdData read response
//   Mem*                  : muxed memory request, MemRdData sync-read q
// -----------------------------------------------------------------------------
module rvc_asap_5pl_dmem_arb
    import rvc_asap_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    // Legal range 1..255.
    parameter int STARVE_MAX = DMEM_ARB_STARVE_MAX
) (
    input  logic                  Clock,
    input  logic                  Rst,
    input  logic                  CoreReq,
    input  logic                  CoreWrEn,
    input  logic [ADDR_W-1:0]     CoreAddr,
    input  logic [DATA_W-1:0]     CoreWrData,
    input  logic [DATA_W/8-1:0]   CoreByteEn,
    output logic                  CoreStall,
    output logic [DATA_W-1:0]     CoreRdDataQ104H,
    input  logic                  ExtReq,
    input  logic                  ExtWrEn,
    input  logic [ADDR_W-1:0]     ExtAddr,
    input  logic [DATA_W-1:0]     ExtWrData,
    input  logic [DATA_W/8-1:0]   ExtByteEn,
    output logic                  ExtGnt,
    output logic                  ExtRspValid,
    output logic [DATA_W-1:0]     ExtRdData,
    output logic [ADDR_W-1:0]     MemAddr,
    output logic [DATA_W-1:0]     MemWrData,
    output logic [DATA_W/8-1:0]   MemByteEn,
    output logic                  MemWrEn,
    output logic                  MemRdEn,
    input  logic [DATA_W-1:0]     MemRdData
);

    localparam int                CNT_W        = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0]  STARVE_MAX_C = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] starve_cnt_q;
    logic [CNT_W-1:0] starve_cnt_d;
    t_dmem_owner      rsp_owner_q;
    t_dmem_owner      rsp_owner_d;
    logic             ext_win_s;
    logic             core_gnt_s;

    // Grant decision; everything is held off while reset is asserted.
    always_comb begin
        ext_win_s  = 1'b0;
        core_gnt_s = 1'b0;
        if (Rst) begin
            ext_win_s  = ExtReq && (!CoreReq || (starve_cnt_q == STARVE_MAX_C));
            core_gnt_s = CoreReq && !ext_win_s;
        end else begin
            ext_win_s  = 1'b0;
            core_gnt_s = 1'b0;
        end
    end

    // Memory request mux; address/data follow the core when idle (don't-care).
    always_comb begin
        MemAddr   = CoreAddr;
        MemWrData = CoreWrData;
        MemByteEn = CoreByteEn;
        MemWrEn   = 1'b0;
        MemRdEn   = 1'b0;
        if (ext_win_s) begin
            MemAddr   = ExtAddr;
            MemWrData = ExtWrData;
            MemByteEn = ExtByteEn;
            MemWrEn   = ExtWrEn;
            MemRdEn   = !ExtWrEn;
        end else if (core_gnt_s) begin
            MemWrEn   = CoreWrEn;
            MemRdEn   = !CoreWrEn;
        end else begin
            MemWrEn   = 1'b0;
            MemRdEn   = 1'b0;
        end
    end

    // Starvation counter and response owner next-state.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        rsp_owner_d  = OWN_NONE;
        // Counter only runs while the external master is actually waiting.
        if (!ExtReq || ext_win_s) begin
            starve_cnt_d = '0;
        end else if (core_gnt_s && (starve_cnt_q != STARVE_MAX_C)) begin
            starve_cnt_d = starve_cnt_q + CNT_W'(1);
        end else begin
            starve_cnt_d = starve_cnt_q;
        end
        // Only reads produce a response the cycle after grant.
        if (ext_win_s && !ExtWrEn) begin
            rsp_owner_d = OWN_EXT;
        end else if (core_gnt_s && !CoreWrEn) begin
            rsp_owner_d = OWN_CORE;
        end else begin
            rsp_owner_d = OWN_NONE;
        end
    end

    // State registers; reset drops any in-flight response.
    always_ff @(posedge Clock or negedge Rst) begin
        if (!Rst) begin
            starve_cnt_q <= '0;
            rsp_owner_q  <= OWN_NONE;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            rsp_owner_q  <= rsp_owner_d;
        end
    end

    // Handshake and response steering.
    always_comb begin
        ExtGnt          = ext_win_s;
        CoreStall       = CoreReq && ext_win_s;
        ExtRspValid     = (rsp_owner_q == OWN_EXT);
        ExtRdData       = MemRdData;
        CoreRdDataQ104H = '0;
        if (rsp_owner_q == OWN_CORE) begin
            CoreRdDataQ104H = MemRdData;
        end else begin
            CoreRdDataQ104H = '0;
        end
    end

endmodule

// File: tb/tb_rvc_asap_5pl_dmem_arb.sv
// -----------------------------------------------------------------------------
// tb_rvc_asap_5pl_dmem_arb
// Self-checking bench: sync-read memory model, shadow copy of expected memory
// contents, and a response scoreboard fed with the owner/data the bench
// expects for every cycle and drained one cycle later.
// -----------------------------------------------------------------------------
module tb_rvc_asap_5pl_dmem_arb;

    localparam int STARVE_MAX = 8;
    localparam int R_NONE     = 0;
    localparam int R_CORE     = 1;
    localparam int R_EXT      = 2;

    typedef struct {
        int          own;
        logic [31:0] data;
    } rsp_t;

    logic        Clock;
    logic        Rst;
    logic        CoreReq;
    logic        CoreWrEn;
    logic [31:0] CoreAddr;
    logic [31:0] CoreWrData;
    logic [3:0]  CoreByteEn;
    logic        CoreStall;
    logic [31:0] CoreRdDataQ104H;
    logic        ExtReq;
    logic        ExtWrEn;
    logic [31:0] ExtAddr;
    logic [31:0] ExtWrData;
    logic [3:0]  ExtByteEn;
    logic        ExtGnt;
    logic        ExtRspValid;
    logic [31:0] ExtRdData;
    logic [31:0] MemAddr;
    logic [31:0] MemWrData;
    logic [3:0]  MemByteEn;
    logic        MemWrEn;
    logic        MemRdEn;
    logic [31:0] MemRdData;

    logic [31:0] mem [0:1023];
    logic [31:0] shadow [0:1023];
    logic [31:0] mem_q;
    rsp_t        exp_q[$];
    int          n_vec;
    int          n_err;

    rvc_asap_5pl_dmem_arb #(
        .ADDR_W     (32),
        .DATA_W     (32),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .Clock           (Clock),
        .Rst             (Rst),
        .CoreReq         (CoreReq),
        .CoreWrEn        (CoreWrEn),
        .CoreAddr        (CoreAddr),
        .CoreWrData      (CoreWrData),
        .CoreByteEn      (CoreByteEn),
        .CoreStall       (CoreStall),
        .CoreRdDataQ104H (CoreRdDataQ104H),
        .ExtReq          (ExtReq),
        .ExtWrEn         (ExtWrEn),
        .ExtAddr         (ExtAddr),
        .ExtWrData       (ExtWrData),
        .ExtByteEn       (ExtByteEn),
        .ExtGnt          (ExtGnt),
        .ExtRspValid     (ExtRspValid),
        .ExtRdData       (ExtRdData),
        .MemAddr         (MemAddr),
        .MemWrData       (MemWrData),
        .MemByteEn       (MemByteEn),
        .MemWrEn         (MemWrEn),
        .MemRdEn         (MemRdEn),
        .MemRdData       (MemRdData)
    );

    // Clock generator.
    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    // Sync-read, byte-writable data memory model.
    always @(posedge Clock) begin
        if (MemWrEn) begin
            for (int b = 0; b < 4; b++) begin
                if (MemByteEn[b]) mem[MemAddr[11:2]][8*b +: 8] <= MemWrData[8*b +: 8];
            end
        end
        if (MemRdEn) mem_q <= mem[MemAddr[11:2]];
    end
    assign MemRdData = mem_q;

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
        end
        return r;
    endfunction

    task automatic idle_inputs();
        CoreReq    = 1'b0;
        CoreWrEn   = 1'b0;
        CoreAddr   = 32'h0000_1000;
        CoreWrData = 32'h0000_0000;
        CoreByteEn = 4'hF;
        ExtReq     = 1'b0;
        ExtWrEn    = 1'b0;
        ExtAddr    = 32'h0000_1000;
        ExtWrData  = 32'h0000_0000;
        ExtByteEn  = 4'hF;
    endtask

    // Push this cycle's expected response, advance a cycle, drain and compare.
    task automatic tick(input int own, input logic [31:0] data);
        rsp_t e;
        logic [31:0] core_exp;
        exp_q.push_back('{own: own, data: data});
        @(posedge Clock);
        #1;
        e = exp_q.pop_front();
        core_exp = (e.own == R_CORE) ? e.data : 32'h0000_0000;
        n_vec++;
        if (ExtRspValid !== (e.own == R_EXT)) begin
            n_err++;
            $display("FAIL rsp_valid t=%0t: ExtRspValid=%b expected %b", $time, ExtRspValid, (e.own == R_EXT));
        end
        n_vec++;
        if (CoreRdDataQ104H !== core_exp) begin
            n_err++;
            $display("FAIL core_rdata t=%0t: got %h expected %h", $time, CoreRdDataQ104H, core_exp);
        end
        if (e.own == R_EXT) begin
            n_vec++;
            if (ExtRdData !== e.data) begin
                n_err++;
                $display("FAIL ext_rdata t=%0t: got %h expected %h", $time, ExtRdData, e.data);
            end
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        CoreReq = 1'b1;
        ExtReq  = 1'b1;
        #2;
        n_vec++;
        if ({ExtGnt, CoreStall, MemWrEn, MemRdEn, ExtRspValid} !== 5'b00000) begin
            n_err++;
            $display("FAIL reset_strobes: gnt/stall/wr/rd/rspv=%b expected 00000",
                     {ExtGnt, CoreStall, MemWrEn, MemRdEn, ExtRspValid});
        end
        n_vec++;
        if (CoreRdDataQ104H !== 32'h0000_0000) begin
            n_err++;
            $display("FAIL reset_core_rdata: got %h expected 00000000", CoreRdDataQ104H);
        end
        @(posedge Clock);
        #1;
        idle_inputs();
        Rst = 1'b1;
    endtask

    task automatic test_core_read();
        CoreReq  = 1'b1;
        CoreWrEn = 1'b0;
        CoreAddr = 32'h0000_1000;
        #1;
        n_vec++;
        if (MemRdEn !== 1'b1 || CoreStall !== 1'b0 || MemAddr !== 32'h0000_1000) begin
            n_err++;
            $display("FAIL core_read_req: rd=%b stall=%b addr=%h expected 1 0 00001000",
                     MemRdEn, CoreStall, MemAddr);
        end
        tick(R_CORE, shadow[0]);
        idle_inputs();
    endtask

    task automatic test_ext_write();
        ExtReq    = 1'b1;
        ExtWrEn   = 1'b1;
        ExtAddr   = 32'h0000_1004;
        ExtWrData = 32'h1234_5678;
        ExtByteEn = 4'hF;
        #1;
        n_vec++;
        if (ExtGnt !== 1'b1 || MemWrEn !== 1'b1 || MemRdEn !== 1'b0 || MemWrData !== 32'h1234_5678) begin
            n_err++;
            $display("FAIL ext_write: gnt=%b wr=%b rd=%b data=%h expected 1 1 0 12345678",
                     ExtGnt, MemWrEn, MemRdEn, MemWrData);
        end
        shadow[1] = merge(shadow[1], 32'h1234_5678, 4'hF);
        tick(R_NONE, 32'h0);
        idle_inputs();
        // Partial core write, later read back by the external master.
        CoreReq    = 1'b1;
        CoreWrEn   = 1'b1;
        CoreAddr   = 32'h0000_1008;
        CoreWrData = 32'hCAFE_F00D;
        CoreByteEn = 4'b0011;
        #1;
        n_vec++;
        if (MemWrEn !== 1'b1 || MemByteEn !== 4'b0011 || ExtGnt !== 1'b0) begin
            n_err++;
            $display("FAIL core_write: wr=%b be=%b gnt=%b expected 1 0011 0", MemWrEn, MemByteEn, ExtGnt);
        end
        shadow[2] = merge(shadow[2], 32'hCAFE_F00D, 4'b0011);
        tick(R_NONE, 32'h0);
        idle_inputs();
        CoreReq  = 1'b1;
        CoreAddr = 32'h0000_1004;
        tick(R_CORE, shadow[1]);
        idle_inputs();
    endtask

    task automatic test_starvation();
        CoreReq  = 1'b1;
        CoreAddr = 32'h0000_1000;
        ExtReq   = 1'b1;
        ExtWrEn  = 1'b0;
        ExtAddr  = 32'h0000_1008;
        for (int i = 0; i < STARVE_MAX; i++) begin
            #1;
            n_vec++;
            if (ExtGnt !== 1'b0 || CoreStall !== 1'b0 || MemAddr !== 32'h0000_1000) begin
                n_err++;
                $display("FAIL starve_core_%0d: gnt=%b stall=%b addr=%h expected 0 0 00001000",
                         i, ExtGnt, CoreStall, MemAddr);
            end
            tick(R_CORE, shadow[0]);
        end
        #1;
        n_vec++;
        if (ExtGnt !== 1'b1 || CoreStall !== 1'b1 || MemRdEn !== 1'b1 || MemAddr !== 32'h0000_1008) begin
            n_err++;
            $display("FAIL starve_ext_win: gnt=%b stall=%b rd=%b addr=%h expected 1 1 1 00001008",
                     ExtGnt, CoreStall, MemRdEn, MemAddr);
        end
        tick(R_EXT, shadow[2]);
        ExtReq = 1'b0;
        #1;
        n_vec++;
        if (CoreStall !== 1'b0 || MemRdEn !== 1'b1) begin
            n_err++;
            $display("FAIL starve_core_after: stall=%b rd=%b expected 0 1", CoreStall, MemRdEn);
        end
        tick(R_CORE, shadow[0]);
        idle_inputs();
    endtask

    task automatic test_simultaneous();
        tick(R_NONE, 32'h0);
        CoreReq  = 1'b1;
        CoreAddr = 32'h0000_1004;
        ExtReq   = 1'b1;
        ExtAddr  = 32'h0000_1000;
        #1;
        n_vec++;
        if (ExtGnt !== 1'b0 || CoreStall !== 1'b0 || MemAddr !== 32'h0000_1004) begin
            n_err++;
            $display("FAIL simultaneous: gnt=%b stall=%b addr=%h expected 0 0 00001004",
                     ExtGnt, CoreStall, MemAddr);
        end
        tick(R_CORE, shadow[1]);
        // Core withdraws, the waiting external read goes through.
        CoreReq = 1'b0;
        #1;
        n_vec++;
        if (ExtGnt !== 1'b1) begin
            n_err++;
            $display("FAIL simultaneous_ext: gnt=%b expected 1", ExtGnt);
        end
        tick(R_EXT, shadow[0]);
        idle_inputs();
    endtask

    task automatic test_back_to_back();
        CoreReq = 1'b1;
        for (int i = 0; i < 4; i++) begin
            CoreAddr = 32'h0000_1000 + 32'(4 * i);
            tick(R_CORE, shadow[i]);
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid_read();
        ExtReq  = 1'b1;
        ExtAddr = 32'h0000_1008;
        #1;
        n_vec++;
        if (ExtGnt !== 1'b1) begin
            n_err++;
            $display("FAIL rmr_grant: gnt=%b expected 1", ExtGnt);
        end
        tick(R_EXT, shadow[2]);
        Rst     = 1'b0;
        ExtAddr = 32'h0000_1004;
        CoreReq = 1'b1;
        #1;
        n_vec++;
        if ({ExtRspValid, ExtGnt, CoreStall, MemWrEn, MemRdEn} !== 5'b00000) begin
            n_err++;
            $display("FAIL rmr_in_reset: rspv/gnt/stall/wr/rd=%b expected 00000",
                     {ExtRspValid, ExtGnt, CoreStall, MemWrEn, MemRdEn});
        end
        @(posedge Clock);
        #1;
        n_vec++;
        if ({ExtRspValid, ExtGnt, CoreStall, MemWrEn, MemRdEn} !== 5'b00000 ||
            CoreRdDataQ104H !== 32'h0000_0000) begin
            n_err++;
            $display("FAIL rmr_hold: rspv/gnt/stall/wr/rd=%b core_rdata=%h expected 00000 00000000",
                     {ExtRspValid, ExtGnt, CoreStall, MemWrEn, MemRdEn}, CoreRdDataQ104H);
        end
        CoreReq = 1'b0;
        Rst     = 1'b1;
        #1;
        n_vec++;
        if (ExtGnt !== 1'b1 || MemRdEn !== 1'b1 || MemAddr !== 32'h0000_1004) begin
            n_err++;
            $display("FAIL rmr_after: gnt=%b rd=%b addr=%h expected 1 1 00001004", ExtGnt, MemRdEn, MemAddr);
        end
        tick(R_EXT, shadow[1]);
        idle_inputs();
        tick(R_NONE, 32'h0);
    endtask

    // Test sequence.
    initial begin
        n_vec = 0;
        n_err = 0;
        Rst   = 1'b0;
        for (int i = 0; i < 1024; i++) begin
            shadow[i] = 32'h5A00_0000 ^ (32'(i) * 32'h0001_0101);
            mem[i]   <= 32'h5A00_0000 ^ (32'(i) * 32'h0001_0101);
        end
        shadow[0] = 32'hDEAD_BEEF;
        mem[0]   <= 32'hDEAD_BEEF;
        test_reset();
        test_core_read();
        test_ext_write();
        test_starvation();
        test_simultaneous();
        test_back_to_back();
        test_reset_mid_read();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
